ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Sits between command sources and the single-port RAM.
- Shares the RAM's 10-bit command interface (din/rx_valid in, dout/tx_valid out) between requester 0 (SPI slave, no backpressure) and requester 1 (local parallel port with valid/ready).
- Keeps each requester's address+data command pair atomic, because the RAM holds one shared write-address and one shared read-address register.
- Routes read data back to the requester that issued the read.

Parameters:
- FIFO_DEPTH, 4, depth of requester-0 command buffer (power of 2, ≥2).
- LOCK_TIMEOUT, 64, idle cycles an owner may hold the lock before forced release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s0_din  in  10  SPI command word; [9:8] opcode, [7:0] payload.
- s0_valid  in  1  one-cycle pulse, s0_din valid; cannot be stalled.
- s0_dout  out  8  read data to SPI.
- s0_tx_valid  out  1  one-cycle pulse, s0_dout valid.
- s1_din  in  10  local command word, same encoding.
- s1_valid  in  1  local command pending.
- s1_ready  out  1  local command accepted this cycle.
- s1_dout  out  8  read data to local port.
- s1_tx_valid  out  1  one-cycle pulse, s1_dout valid.
- ram_din  out  10  command to RAM.
- ram_rx_valid  out  1  one-cycle command strobe to RAM.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.
- grant  out  2  one-hot current lock owner; 00 when free.
- s0_overflow  out  1  sticky: requester-0 command dropped.
- lock_timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Opcodes: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data. The RAM answers 11 with ram_tx_valid.
- Reset: all outputs 0; FIFO empty; state IDLE; counter 0; last_grant = 1, so s0 wins the first tie.
- s0 FIFO:
  - s0_valid writes s0_din when not full.
  - When full, the word is dropped and s0_overflow is set; it is cleared only by reset.
  - Push and pop in the same cycle while full is allowed; nothing is dropped.
- Requests: r0 = FIFO not empty; r1 = s1_valid.
- A command is accepted at edge t when the FSM selects a requester. At t+1, ram_rx_valid=1 for exactly one cycle and ram_din holds the command.
- For s1, acceptance means s1_ready=1 in the cycle before edge t (s1_ready is combinational from state and request). For s0, acceptance pops the FIFO.
- One command is issued per cycle at most.
- FSM states:
  - IDLE:
    - Arbitrate round-robin; with both requesting, grant the one that is not last_grant. Update last_grant.
    - Opcode 00 → OWN_W; 10 → OWN_R; 01 → issue, stay IDLE; 11 → RD_WAIT.
  - OWN_W / OWN_R:
    - grant holds the owner. Only the owner's commands are accepted; the other requester waits (s1_ready=0, FIFO holds).
    - 00 → OWN_W; 10 → OWN_R; 01 from OWN_W → IDLE; 01 from OWN_R → stay OWN_R; 11 → RD_WAIT.
    - The counter resets on every owner command and increments otherwise.
    - When the counter reaches LOCK_TIMEOUT, go to IDLE, pulse lock_timeout, and set last_grant to the owner.
  - RD_WAIT:
    - No commands are accepted.
    - On ram_tx_valid, register ram_dout to the owner's dout and pulse its tx_valid one cycle later; go to IDLE.
    - The same timeout applies, with the counter incrementing every cycle.
- ram_tx_valid outside RD_WAIT is ignored; no tx_valid is produced.
- grant is registered and equals the owner in OWN_*/RD_WAIT; 00 in IDLE.
- Reset asserted mid-sequence returns to the reset values immediately; FIFO contents are lost.

Test Plan:
- s0 pushes 0x005, 0x1A5 (write addr 5, data A5), then 0x205, 0x300 → ram_din sees 0x005, 0x1A5, 0x205, 0x300 in order. ram_tx_valid with ram_dout=0xA5 → s0_tx_valid one cycle later with s0_dout=0xA5; s1_tx_valid stays 0.
- Both idle and requesting in the same cycle (s0 0x010, s1 0x020) → s0 granted first (grant=01). s1 is held with s1_ready=0 until s0 sends 0x1xx and completes, then granted (grant=10).
- s1 holds the lock with 0x033 and then goes silent for 64 cycles; s0 is pending → lock_timeout pulses at cycle 64, grant returns to 00, and the next grant is s0.
- Six s0_valid pulses in consecutive cycles while s1 owns the lock → 4 words buffered, s0_overflow=1 after the 5th. The 4 words are issued in order once s0 is granted.
- s1 issues 0x300 and rst_n is asserted during RD_WAIT → all outputs 0 and grant=00 asynchronously. After release, the first arbitration is won by s0.
- Orphan 0x1FF from s1 in IDLE → issued once; state stays IDLE; grant stays 00.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares the single-port RAM's 10-bit command interface between two requesters.
// An address command takes a lock so that the address/data pair that follows it
// cannot be interleaved with the other requester's commands. Read data goes back
// to the requester that issued the read.
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   s0_din/s0_valid         : SPI command stream (no backpressure, buffered)
//   s0_dout/s0_tx_valid     : read data back to SPI
//   s1_din/s1_valid/s1_ready: local command port with valid/ready handshake
//   s1_dout/s1_tx_valid     : read data back to local port
//   ram_din/ram_rx_valid    : command strobe towards the RAM
//   ram_dout/ram_tx_valid   : RAM read data
//   grant                   : one-hot lock owner, 00 when free
//   s0_overflow             : sticky, an SPI command was dropped
//   lock_timeout            : one-cycle pulse when an idle owner loses the lock
module ram_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] s0_din,
    input  logic       s0_valid,
    output logic [7:0] s0_dout,
    output logic       s0_tx_valid,
    input  logic [9:0] s1_din,
    input  logic       s1_valid,
    output logic       s1_ready,
    output logic [7:0] s1_dout,
    output logic       s1_tx_valid,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic [1:0] grant,
    output logic       s0_overflow,
    output logic       lock_timeout
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
    // The pulse is registered, so the release decision is taken one count early.
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_W   = 2'd1,
        OWN_R   = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    state_t           state_r;
    logic             owner_r;       // 0: s0, 1: s1
    logic             last_grant_r;  // 0: s0, 1: s1
    logic [CNT_W-1:0] count_r;

    logic [9:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   fill_r;

    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;
    logic             sel0_s;
    logic             sel1_s;
    logic             accept_s;
    logic [9:0]       cmd_s;
    logic             at_limit_s;

    function automatic logic [1:0] grant_of(input logic owner);
        grant_of = owner ? 2'b10 : 2'b01;
    endfunction

    assign fifo_empty_s = (fill_r == (PTR_W+1)'(0));
    assign fifo_full_s  = (fill_r == (PTR_W+1)'(FIFO_DEPTH));
    assign pop_s        = sel0_s;
    // A pop in the same cycle frees a slot, so a full FIFO still takes the word.
    assign push_s       = s0_valid && (!fifo_full_s || pop_s);
    assign drop_s       = s0_valid && fifo_full_s && !pop_s;
    assign accept_s     = sel0_s || sel1_s;
    assign cmd_s        = sel1_s ? s1_din : fifo_mem_r[rd_ptr_r];
    assign at_limit_s   = (count_r == COUNT_LAST);
    assign s1_ready     = sel1_s;

    // Select which requester, if any, has its command accepted this cycle.
    always_comb begin
        sel0_s = 1'b0;
        sel1_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && s1_valid) begin
                    if (last_grant_r) begin
                        sel0_s = 1'b1;
                    end else begin
                        sel1_s = 1'b1;
                    end
                end else if (!fifo_empty_s) begin
                    sel0_s = 1'b1;
                end else if (s1_valid) begin
                    sel1_s = 1'b1;
                end else begin
                    sel0_s = 1'b0;
                    sel1_s = 1'b0;
                end
            end
            OWN_W, OWN_R: begin
                if (owner_r) begin
                    sel1_s = s1_valid;
                end else begin
                    sel0_s = !fifo_empty_s;
                end
            end
            RD_WAIT: begin
                sel0_s = 1'b0;
                sel1_s = 1'b0;
            end
            default: begin
                sel0_s = 1'b0;
                sel1_s = 1'b0;
            end
        endcase
    end

    // Requester-0 FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= s0_din;
        end
    end

    // Requester-0 FIFO pointers and fill level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            fill_r   <= (PTR_W+1)'(0);
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   fill_r <= fill_r + (PTR_W+1)'(1);
                2'b01:   fill_r <= fill_r - (PTR_W+1)'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Arbitration FSM, lock counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            count_r      <= CNT_W'(0);
            ram_din      <= 10'd0;
            ram_rx_valid <= 1'b0;
            s0_dout      <= 8'd0;
            s0_tx_valid  <= 1'b0;
            s1_dout      <= 8'd0;
            s1_tx_valid  <= 1'b0;
            grant        <= 2'b00;
            s0_overflow  <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            ram_rx_valid <= accept_s;
            s0_tx_valid  <= 1'b0;
            s1_tx_valid  <= 1'b0;
            lock_timeout <= 1'b0;
            if (drop_s) begin
                s0_overflow <= 1'b1;
            end
            if (accept_s) begin
                // Outside IDLE only the owner is selected, so sel1_s names the owner.
                ram_din <= cmd_s;
                count_r <= CNT_W'(0);
                if (state_r == IDLE) begin
                    owner_r      <= sel1_s;
                    last_grant_r <= sel1_s;
                end
                case (cmd_s[9:8])
                    2'b00: begin
                        state_r <= OWN_W;
                        grant   <= grant_of(sel1_s);
                    end
                    2'b10: begin
                        state_r <= OWN_R;
                        grant   <= grant_of(sel1_s);
                    end
                    2'b01: begin
                        // Write data completes a write pair; read-addr lock survives it.
                        if (state_r == OWN_R) begin
                            state_r <= OWN_R;
                            grant   <= grant_of(sel1_s);
                        end else begin
                            state_r <= IDLE;
                            grant   <= 2'b00;
                        end
                    end
                    2'b11: begin
                        state_r <= RD_WAIT;
                        grant   <= grant_of(sel1_s);
                    end
                    default: begin
                        state_r <= IDLE;
                        grant   <= 2'b00;
                    end
                endcase
            end else begin
                case (state_r)
                    OWN_W, OWN_R: begin
                        if (at_limit_s) begin
                            state_r      <= IDLE;
                            grant        <= 2'b00;
                            lock_timeout <= 1'b1;
                            last_grant_r <= owner_r;
                            count_r      <= CNT_W'(0);
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                    RD_WAIT: begin
                        if (ram_tx_valid) begin
                            state_r <= IDLE;
                            grant   <= 2'b00;
                            count_r <= CNT_W'(0);
                            if (owner_r) begin
                                s1_dout     <= ram_dout;
                                s1_tx_valid <= 1'b1;
                            end else begin
                                s0_dout     <= ram_dout;
                                s0_tx_valid <= 1'b1;
                            end
                        end else if (at_limit_s) begin
                            state_r      <= IDLE;
                            grant        <= 2'b00;
                            lock_timeout <= 1'b1;
                            last_grant_r <= owner_r;
                            count_r      <= CNT_W'(0);
                        end else begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        count_r <= CNT_W'(0);
                    end
                endcase
            end
        end
    end

endmodule
